// File: rtl/ooo_pkg.sv
// Shared out-of-order core parameters and the retirement-RAT walk state encoding.
// No logic; types and constants only.
// Imported by the RRAT interface, walker and top.
package ooo_pkg;

  localparam int NUM_AREG = 32;  // architectural registers, entry 0 is $zero
  localparam int AREG_W   = 5;   // architectural register index width
  localparam int PREG_W   = 6;   // physical register index width (64 regs)

  // Walk counter carries one extra bit so the terminal count never aliases entry 0.
  localparam int WALK_W = AREG_W + 1;

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [WALK_W-1:0] walk_cnt_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } rrat_state_t;

  // Index of the final entry in a recovery walk.
  localparam walk_cnt_t WALK_LAST = walk_cnt_t'(NUM_AREG - 1);

  // True when a commit actually writes the map ($zero is never remapped).
  function automatic logic commit_accepted(input logic vld, input areg_t areg);
    return vld && (areg != '0);
  endfunction

endpackage

// File: rtl/rrat_recovery_if.sv
// Bundle between the ROB commit/flush side and the retirement RAT.
// Latency: n/a (wires only).
// Backpressure: none; the master sees rec_busy as its stall indication.
interface rrat_recovery_if;

  // commit / flush from the reorder buffer
  logic                   commit_valid;
  logic [ooo_pkg::AREG_W-1:0] commit_areg;
  logic [ooo_pkg::PREG_W-1:0] commit_preg;
  logic                   flush;

  // free-list return
  logic                   free_valid;
  logic [ooo_pkg::PREG_W-1:0] free_preg;

  // recovery stream towards the front-end RAT
  logic                   rec_valid;
  logic [ooo_pkg::AREG_W-1:0] rec_areg;
  logic [ooo_pkg::PREG_W-1:0] rec_preg;
  logic                   rec_busy;
  logic                   rec_done;

  // sticky duplicate-mapping error
  logic                   dup_err;

  // ROB / front-end side
  modport master (
    output commit_valid, commit_areg, commit_preg, flush,
    input  free_valid, free_preg,
    input  rec_valid, rec_areg, rec_preg, rec_busy, rec_done,
    input  dup_err
  );

  // retirement RAT side
  modport slave (
    input  commit_valid, commit_areg, commit_preg, flush,
    output free_valid, free_preg,
    output rec_valid, rec_areg, rec_preg, rec_busy, rec_done,
    output dup_err
  );

endinterface

// File: rtl/rrat_walker.sv
// Recovery walk sequencer: IDLE/RECOVER FSM, entry counter, valid/busy/done strobes.
// Latency: first entry one cycle after flush is sampled; done pulses one cycle after the last entry.
// Backpressure: none; rec_busy asserts combinationally on flush and holds through the walk.
module rrat_walker
  import ooo_pkg::*;
(
  input  logic  clk,
  input  logic  reset,      // asynchronous, active-low
  input  logic  flush,
  output logic  rec_valid,
  output areg_t rec_idx,
  output logic  rec_busy,
  output logic  rec_done
);

  rrat_state_t state_q, state_d;
  walk_cnt_t   cnt_q, cnt_d;
  logic        done_q, done_d;

  // State, counter and done-pulse registers; reset aborts any walk without a done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state and stream outputs; a flush always (re)starts the walk at entry 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rec_valid = 1'b0;
    rec_idx   = '0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end
      end
      RECOVER: begin
        rec_valid = 1'b1;
        rec_idx   = cnt_q[AREG_W-1:0];
        if (flush) begin
          // aborted walk: restart, and the pending done is never raised
          cnt_d = '0;
        end else if (cnt_q == WALK_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + walk_cnt_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Rename must stall in the flush cycle itself, before the FSM has moved.
  assign rec_busy = flush | (state_q == RECOVER);
  assign rec_done = done_q;

endmodule

// File: rtl/rrat_recovery.sv
// Retirement RAT: committed arch->phys map, superseded-register free return, flush-time map replay.
// Latency: free_* one cycle after commit; recovery stream one entry/cycle starting the cycle after flush.
// Backpressure: none accepted; rename stalls on rec_busy. Optional dup check under RRAT_DUP_CHECK_EN.
module rrat_recovery
  import ooo_pkg::*;
(
  input  logic           clk,
  input  logic           reset,   // asynchronous, active-low
  rrat_recovery_if.slave bus
);

  preg_t map_q [NUM_AREG];
  preg_t map_d [NUM_AREG];

  logic  free_valid_q, free_valid_d;
  preg_t free_preg_q,  free_preg_d;

  logic  commit_acc;
  preg_t old_preg;

  logic  walk_vld;
  areg_t walk_idx;

  assign commit_acc = commit_accepted(bus.commit_valid, bus.commit_areg);
  assign old_preg   = map_q[bus.commit_areg];

  // Map and free-return registers; reset restores the identity mapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        map_q[i] <= preg_t'(i);
      end
      free_valid_q <= 1'b0;
      free_preg_q  <= '0;
    end else begin
      map_q        <= map_d;
      free_valid_q <= free_valid_d;
      free_preg_q  <= free_preg_d;
    end
  end

  // Commit update and the register it supersedes; re-committing the same mapping frees nothing.
  always_comb begin
    map_d        = map_q;
    free_valid_d = 1'b0;
    free_preg_d  = '0;
    if (commit_acc) begin
      map_d[bus.commit_areg] = bus.commit_preg;
      if (old_preg != bus.commit_preg) begin
        free_valid_d = 1'b1;
        free_preg_d  = old_preg;
      end
    end
  end

  assign bus.free_valid = free_valid_q;
  assign bus.free_preg  = free_preg_q;

  rrat_walker u_walker (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .rec_valid (walk_vld),
    .rec_idx   (walk_idx),
    .rec_busy  (bus.rec_busy),
    .rec_done  (bus.rec_done)
  );

  // The stream reads the live map, so a commit landing with (or after) the flush is replayed.
  assign bus.rec_valid = walk_vld;
  assign bus.rec_areg  = walk_idx;
  assign bus.rec_preg  = walk_vld ? map_q[walk_idx] : '0;

`ifdef RRAT_DUP_CHECK_EN
  logic dup_hit;
  logic dup_err_q, dup_err_d;

  // Does the incoming physical register already back some other architectural register?
  always_comb begin
    dup_hit = 1'b0;
    for (int j = 0; j < NUM_AREG; j++) begin
      if ((areg_t'(j) != bus.commit_areg) && (map_q[j] == bus.commit_preg)) begin
        dup_hit = 1'b1;
      end
    end
  end

  // Sticky error: only reset clears it.
  always_comb begin
    dup_err_d = dup_err_q | (commit_acc & dup_hit);
  end

  // Error flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dup_err_q <= 1'b0;
    end else begin
      dup_err_q <= dup_err_d;
    end
  end

  assign bus.dup_err = dup_err_q;
`else
  assign bus.dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_rrat_recovery.sv
// Bench for rrat_recovery: directed scenarios plus randomized commit/flush/reset traffic,
// compared every cycle against an array-based model of the committed map and walk position.
module tb_rrat_recovery;
  import ooo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rrat_recovery_if bus();

  rrat_recovery dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  logic [PREG_W-1:0] m_map [NUM_AREG];
  int                m_walk;        // -1 when idle, else entry being presented
  logic              m_done;
  logic              m_free_vld;
  logic [PREG_W-1:0] m_free_preg;
  logic              m_dup;
  logic              m_acc;
  logic [PREG_W-1:0] m_old;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AREG; i++) m_map[i] = i[PREG_W-1:0];
      m_walk      = -1;
      m_done      = 1'b0;
      m_free_vld  = 1'b0;
      m_free_preg = '0;
      m_dup       = 1'b0;
    end else begin
      m_acc = bus.commit_valid && (bus.commit_areg != 0);
      m_old = m_map[bus.commit_areg];
      m_free_vld  = m_acc && (m_old != bus.commit_preg);
      m_free_preg = m_free_vld ? m_old : '0;
      if (m_acc) begin
        for (int j = 0; j < NUM_AREG; j++)
          if (j != int'(bus.commit_areg) && m_map[j] == bus.commit_preg) m_dup = 1'b1;
        m_map[bus.commit_areg] = bus.commit_preg;
      end
      m_done = 1'b0;
      if (bus.flush) m_walk = 0;
      else if (m_walk >= 0) begin
        if (m_walk == NUM_AREG - 1) begin
          m_walk = -1;
          m_done = 1'b1;
        end else begin
          m_walk = m_walk + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("free_valid", 32'(bus.free_valid), 32'(m_free_vld));
      chk("free_preg",  32'(bus.free_preg),  32'(m_free_preg));
      chk("rec_valid",  32'(bus.rec_valid),  32'(m_walk >= 0));
      chk("rec_areg",   32'(bus.rec_areg),   (m_walk >= 0) ? 32'(m_walk) : 32'd0);
      chk("rec_preg",   32'(bus.rec_preg),
          (m_walk >= 0) ? 32'(m_map[m_walk[AREG_W-1:0]]) : 32'd0);
      chk("rec_busy",   32'(bus.rec_busy),   32'(bus.flush || (m_walk >= 0)));
      chk("rec_done",   32'(bus.rec_done),   32'(m_done));
`ifdef RRAT_DUP_CHECK_EN
      chk("dup_err",    32'(bus.dup_err),    32'(m_dup));
`else
      chk("dup_err",    32'(bus.dup_err),    32'd0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.commit_valid = 1'b0;
    bus.commit_areg  = '0;
    bus.commit_preg  = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic commit(input int a, input int p);
    bus.commit_valid = 1'b1;
    bus.commit_areg  = a[AREG_W-1:0];
    bus.commit_preg  = p[PREG_W-1:0];
  endtask

  int done_cnt;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (5) step();
    @(negedge clk);
    chk("t1_free_valid", 32'(bus.free_valid), 32'd0);
    chk("t1_rec_busy",   32'(bus.rec_busy),   32'd0);
    chk("t1_rec_valid",  32'(bus.rec_valid),  32'd0);
    chk("t1_rec_done",   32'(bus.rec_done),   32'd0);
    chk("t1_model_map7", 32'(m_map[7]),       32'd7);

    // 2: first commit frees the identity mapping
    step(); commit(5, 40);
    step(); clear_inputs();
    @(negedge clk);
    chk("t2_free_valid", 32'(bus.free_valid), 32'd1);
    chk("t2_free_preg",  32'(bus.free_preg),  32'd5);
    chk("t2_model_map5", 32'(m_map[5]),       32'd40);

    // 3: $zero commit and same-mapping commit free nothing
    step(); commit(0, 33);
    step(); clear_inputs();
    @(negedge clk);
    chk("t3_zero_free", 32'(bus.free_valid), 32'd0);
    step(); commit(5, 40);
    step(); clear_inputs();
    @(negedge clk);
    chk("t3_same_free", 32'(bus.free_valid), 32'd0);

    // 4: full walk
    step(); bus.flush = 1'b1;
    #1;
    chk("t4_busy_in_flush", 32'(bus.rec_busy), 32'd1);
    chk("t4_valid_in_flush", 32'(bus.rec_valid), 32'd0);
    step(); bus.flush = 1'b0;
    for (int i = 0; i < NUM_AREG; i++) begin
      @(negedge clk);
      chk("t4_valid", 32'(bus.rec_valid), 32'd1);
      chk("t4_areg",  32'(bus.rec_areg),  32'(i));
      if (i == 5) chk("t4_preg5", 32'(bus.rec_preg), 32'd40);
      step();
    end
    @(negedge clk);
    chk("t4_done",      32'(bus.rec_done),  32'd1);
    chk("t4_busy_done", 32'(bus.rec_busy),  32'd0);
    step();
    @(negedge clk);
    chk("t4_done_once", 32'(bus.rec_done), 32'd0);

    // 5: re-flush at entry 10 restarts, single done
    step(); bus.flush = 1'b1;
    step(); bus.flush = 1'b0;
    repeat (10) step();
    bus.flush = 1'b1;
    step(); bus.flush = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < NUM_AREG; i++) begin
      @(negedge clk);
      chk("t5_areg", 32'(bus.rec_areg), 32'(i));
      if (bus.rec_done) done_cnt++;
      step();
    end
    @(negedge clk);
    if (bus.rec_done) done_cnt++;
    chk("t5_done_count", 32'(done_cnt), 32'd1);

    // 5b: reset at entry 7
    step(); bus.flush = 1'b1;
    step(); bus.flush = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.rec_valid), 32'd0);
    chk("t5_rst_busy",  32'(bus.rec_busy),  32'd0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_nodone", 32'(bus.rec_done), 32'd0);

    // 6: commit together with flush is replayed
    step(); commit(3, 50); bus.flush = 1'b1;
    step(); clear_inputs();
    for (int i = 0; i < NUM_AREG; i++) begin
      @(negedge clk);
      if (i == 3) chk("t6_preg3", 32'(bus.rec_preg), 32'd50);
      step();
    end
    @(negedge clk);
    chk("t6_done", 32'(bus.rec_done), 32'd1);
`ifdef RRAT_DUP_CHECK_EN
    step(); commit(4, 50);
    step(); clear_inputs();
    @(negedge clk);
    chk("t6_dup_set", 32'(bus.dup_err), 32'd1);
    repeat (5) step();
    @(negedge clk);
    chk("t6_dup_sticky", 32'(bus.dup_err), 32'd1);
`endif

    // Randomized traffic, including commits mid-walk, re-flushes and resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      bus.commit_valid = ($urandom_range(0, 1) == 1);
      bus.commit_areg  = AREG_W'($urandom_range(0, NUM_AREG - 1));
      if ($urandom_range(0, 3) == 0) bus.commit_preg = m_map[bus.commit_areg];
      else bus.commit_preg = PREG_W'($urandom_range(0, 63));
      rst_n = ($urandom_range(0, 499) != 0);
      bus.flush = rst_n && ($urandom_range(0, 39) == 0);
    end
    step();
    clear_inputs();
    rst_n = 1'b1;
    repeat (3) step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
